seq_mac: RTL and testbench
==========================

// Module: seq_mac
// PURPOSE
//  Multi-cycle shift-add multiply-accumulate unit that retires R multiplier bits per cycle.
//  Accepts one operand pair per start/done transaction and adds the product into an ACC_W accumulator.
//  A clear-on-start option and a sticky overflow flag are provided.
//  Used wherever a full-width array multiplier is too large, e.g. filter taps and dot-product engines.
// PARAMETERS
//  N      8          operand width (A and B), N>=2
//  R      2          multiplier bits consumed per cycle, 1<=R<=N; ITER = ceil(N/R)
//  ACC_W  2*N+4      accumulator width, ACC_W>=2*N
// PORTS
//  clk    in   1      clock, rising edge
//  rst    in   1      synchronous reset, active-high
//  start  in   1      request; sampled only in IDLE
//  clr    in   1      sampled with start: 1 = acc <= product, 0 = acc <= acc + product
//  A      in   N      multiplicand, captured at accepted start
//  B      in   N      multiplier, captured at accepted start
//  busy   out  1      state != IDLE
//  done   out  1      one-cycle pulse; P valid from this cycle until the next accepted start
//  P      out  ACC_W  accumulator value
//  ovf    out  1      sticky overflow; cleared by an accepted start with clr=1, or by rst
// BEHAVIOUR
//  Reset: P=0, ovf=0, done=0, busy=0, state=IDLE, digit counter k=0. rst wins over every other input.
//  States:
//   IDLE: start=1 at edge E0 captures A/B/clr, clears partial product pp=0, k=0 -> RUN.
//   RUN: at each edge, pp <= pp + ((A * B[k*R +: R]) << (k*R)), k++.
//        At edge E_ITER: acc updated from the final pp, done=1 -> DONE.
//   DONE: one cycle, then -> IDLE, done=0.
//  Latency: start at E0 -> done high after edge E_ITER; busy falls after E_ITER+1.
//  Throughput: one transaction per ITER+2 cycles.
//  start while busy (RUN or DONE) is ignored; no queuing. clr is ignored without start.
//  B is zero-extended to ITER*R bits when R does not divide N.
//  pp is 2N bits wide and exact.
//  The acc sum is computed at ACC_W+1 bits. Carry-out (unsigned) sets ovf; P keeps the low ACC_W bits (wrap).
//  ovf is never set on a clr=1 transaction, because ACC_W>=2N.
//  A, B and clr inputs may change freely while busy; the captured copies are used.
//  rst during RUN/DONE aborts the transaction: no done pulse, P=0.
// CONFIGURATION
//  SEQ_MAC_SIGNED_EN defined:
//   - A and B are two's complement. B is sign-extended to ITER*R bits and its top digit is treated as signed (negative weight).
//   - A and pp are sign-extended to ACC_W.
//   - ovf = signed overflow: operand signs equal and result sign differs.
//  SEQ_MAC_SIGNED_EN undefined: all operands unsigned, as specified above. No extra ports in either build.
// STRUCTURE
//  Package seq_mac_pkg:
//   - state enum {IDLE, RUN, DONE}
//   - function iter_f(N,R) = ceil(N/R)
//   - localparams ITER and CNT_W = $clog2(ITER+1)
//  Sub-module seq_mac_pp (combinational digit partial-product generator):
//   - inputs: A, digit, k, last-digit flag (signed build)
//   - output: shifted 2N-bit term
//  Top module holds the FSM, k counter, pp register, acc adder and ovf logic.
// TESTING (N=8, R=2, ACC_W=20 unless noted)
//  1 A=13, B=11, clr=1, start -> done exactly 4 edges after start edge, P=143, busy high for 5 cycles.
//  2 Follow-up A=255, B=255, clr=0 -> P=65168, ovf=0.
//    start pulsed during RUN -> ignored, single done.
//  3 Sixteen more 255*255 accumulates with clr=0 -> P wraps on 17th add, ovf=1 and stays 1.
//    Next start with clr=1, A=2, B=3 -> P=6, ovf=0.
//  4 rst asserted on 2nd RUN cycle -> next edge P=0, busy=0, no done.
//    New start then completes normally.
//  5 Sweep R in {1,3,8} with N=8 -> done at ITER = 8, 3, 1 edges after start.
//    Exhaustive 8x8 product check against reference model.
//  6 SEQ_MAC_SIGNED_EN: A=-3, B=5, clr=1 -> P=20'hFFFF1 (-15).
//    A=-128, B=-128 -> P=16384.
//    Accumulate past +2^19-1 -> ovf=1.

Source files
------------

// File: rtl/seq_mac_pkg.sv
`default_nettype none
// ============================================================================
// Module : seq_mac_pkg
// Purpose: Shared types and helpers for the sequential multiply-accumulate
//          unit: FSM state encoding, digit-count helper and the derived
//          constants for the default configuration (N=8, R=2).
// Ports  : none (package)
// Config : SEQ_MAC_SIGNED_EN selects the two's-complement build (see seq_mac).
// Rev    : 1.0  initial release
// ============================================================================
package seq_mac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of R-bit multiplier digits needed to cover an N-bit operand.
  function automatic int iter_f(input int n, input int r);
    return (n + r - 1) / r;
  endfunction

  localparam int DEF_N = 8;
  localparam int DEF_R = 2;
  localparam int ITER  = iter_f(DEF_N, DEF_R);
  localparam int CNT_W = $clog2(ITER + 1);

endpackage
`default_nettype wire

// File: rtl/seq_mac_pp.sv
`default_nettype none
// ============================================================================
// Module : seq_mac_pp
// Purpose: Combinational digit partial-product generator. Multiplies the
//          captured multiplicand by one R-bit multiplier digit and shifts the
//          result to the digit's weight (k*R). Result is 2N bits, modulo 2^2N,
//          which is exact for the final sum of all digit terms.
// Ports  : a     in  N     multiplicand
//          digit in  R     current multiplier digit
//          k     in  K_W   digit index
//          last  in  1     top digit flag (SEQ_MAC_SIGNED_EN build only)
//          term  out 2N    shifted digit product
// Config : SEQ_MAC_SIGNED_EN - a is signed and the top digit has negative
//          weight.
// Rev    : 1.0  initial release
// ============================================================================
module seq_mac_pp #(
  parameter int N   = 8,
  parameter int R   = 2,
  parameter int K_W = 3
) (
  input  logic [N-1:0]   a,
  input  logic [R-1:0]   digit,
  input  logic [K_W-1:0] k,
`ifdef SEQ_MAC_SIGNED_EN
  input  logic           last,
`endif
  output logic [2*N-1:0] term
);

  localparam int W = 2 * N;

  logic [W-1:0] a_ext;
  logic [W-1:0] d_ext;
  logic [W-1:0] prod;

`ifdef SEQ_MAC_SIGNED_EN
  assign a_ext = {{N{a[N-1]}}, a};
  // Only the most significant digit of a two's-complement multiplier carries
  // the sign; all lower digits are plain unsigned magnitudes.
  assign d_ext = last ? {{(W-R){digit[R-1]}}, digit} : {{(W-R){1'b0}}, digit};
`else
  assign a_ext = {{N{1'b0}}, a};
  assign d_ext = {{(W-R){1'b0}}, digit};
`endif

  // Low 2N bits of the product are all that matter: the accumulated sum of
  // terms is congruent to A*B mod 2^2N and A*B always fits in 2N bits.
  assign prod = a_ext * d_ext;
  assign term = prod << (int'(k) * R);

endmodule
`default_nettype wire

// File: rtl/seq_mac.sv
`default_nettype none
// ============================================================================
// Module : seq_mac
// Purpose: Multi-cycle shift-add multiply-accumulate. Each accepted start
//          captures A/B/clr, then retires R multiplier bits per cycle into a
//          2N-bit partial product. On the last digit the product is added to
//          (or, with clr, loaded into) the ACC_W accumulator and done pulses.
// Ports  : clk   in  1      clock, rising edge
//          rst   in  1      synchronous reset, active-high
//          start in  1      request, sampled only in IDLE
//          clr   in  1      with start: 1 = load product, 0 = accumulate
//          A     in  N      multiplicand
//          B     in  N      multiplier
//          busy  out 1      transaction in progress
//          done  out 1      one-cycle completion pulse
//          P     out ACC_W  accumulator
//          ovf   out 1      sticky overflow
// Config : SEQ_MAC_SIGNED_EN - two's-complement operands, signed overflow.
//          Undefined (default) - unsigned operands, carry-out overflow.
// Rev    : 1.0  initial release
// ============================================================================
module seq_mac
  import seq_mac_pkg::*;
#(
  parameter int N     = 8,
  parameter int R     = 2,
  parameter int ACC_W = 2 * N + 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clr,
  input  logic [N-1:0]     A,
  input  logic [N-1:0]     B,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] P,
  output logic             ovf
);

  localparam int DIGITS = iter_f(N, R);
  localparam int K_W    = $clog2(DIGITS + 1);
  localparam int BW     = DIGITS * R;
  localparam int PW     = 2 * N;

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             finish;

  logic [N-1:0]     a_q;
  logic [BW-1:0]    b_q;
  logic [BW-1:0]    b_ext;
  logic [BW-1:0]    b_shift;
  logic             clr_q;
  logic [K_W-1:0]   k;
  logic             last_dig;
  logic [R-1:0]     digit;

  logic [PW-1:0]    pp;
  logic [PW-1:0]    term;
  logic [PW-1:0]    pp_sum;

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_base;
  logic [ACC_W-1:0] pp_ext;
  logic [ACC_W-1:0] acc_sum;
  logic             ovf_now;

  // --------------------------------------------------------------------------
  // Multiplier widened to a whole number of digits.
  // --------------------------------------------------------------------------
  generate
    if (BW > N) begin : g_b_pad
`ifdef SEQ_MAC_SIGNED_EN
      assign b_ext = {{(BW-N){B[N-1]}}, B};
`else
      assign b_ext = {{(BW-N){1'b0}}, B};
`endif
    end else begin : g_b_exact
      assign b_ext = B;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last_dig) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign P    = acc;

  // --------------------------------------------------------------------------
  // Digit selection and partial product
  // --------------------------------------------------------------------------
  assign last_dig = (k == K_W'(DIGITS - 1));
  assign b_shift  = b_q >> (int'(k) * R);
  assign digit    = b_shift[R-1:0];

  seq_mac_pp #(
    .N   (N),
    .R   (R),
    .K_W (K_W)
  ) u_pp (
    .a     (a_q),
    .digit (digit),
    .k     (k),
`ifdef SEQ_MAC_SIGNED_EN
    .last  (last_dig),
`endif
    .term  (term)
  );

  assign pp_sum = pp + term;

  // --------------------------------------------------------------------------
  // Accumulator adder and overflow detection
  // --------------------------------------------------------------------------
  assign acc_base = clr_q ? '0 : acc;

`ifdef SEQ_MAC_SIGNED_EN
  assign pp_ext  = ACC_W'(signed'(pp_sum));
  assign acc_sum = acc_base + pp_ext;
  assign ovf_now = (acc_base[ACC_W-1] == pp_ext[ACC_W-1]) &&
                   (acc_sum[ACC_W-1] != acc_base[ACC_W-1]);
`else
  logic [ACC_W:0] wide_sum;
  assign pp_ext   = ACC_W'(pp_sum);
  assign wide_sum = {1'b0, acc_base} + {1'b0, pp_ext};
  assign acc_sum  = wide_sum[ACC_W-1:0];
  assign ovf_now  = wide_sum[ACC_W];
`endif

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      clr_q <= 1'b0;
      k     <= '0;
      pp    <= '0;
      acc   <= '0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_q   <= A;
      b_q   <= b_ext;
      clr_q <= clr;
      k     <= '0;
      pp    <= '0;
      // A fresh accumulation starts with a clean overflow history.
      if (clr) begin
        ovf <= 1'b0;
      end
    end else if (state == RUN) begin
      pp <= pp_sum;
      k  <= k + 1'b1;
      if (finish) begin
        acc <= acc_sum;
        ovf <= ovf | ovf_now;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_mac.sv
`default_nettype none
// ============================================================================
// Module : tb_seq_mac
// Purpose: Self-checking bench for seq_mac (unsigned build, N=8, ACC_W=20).
//          Main instance uses R=2; three more instances use R=1, 3 and 8.
// Rev    : 1.0  initial release
// ============================================================================
module tb_seq_mac;

  localparam int N     = 8;
  localparam int ACC_W = 20;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             start_sw;
  logic             clr;
  logic [N-1:0]     A;
  logic [N-1:0]     B;

  logic             busy, done, ovf;
  logic [ACC_W-1:0] P;
  logic             busy1, done1, ovf1;
  logic [ACC_W-1:0] P1;
  logic             busy3, done3, ovf3;
  logic [ACC_W-1:0] P3;
  logic             busy8, done8, ovf8;
  logic [ACC_W-1:0] P8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_mac #(.N(N), .R(2), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .clr(clr), .A(A), .B(B),
    .busy(busy), .done(done), .P(P), .ovf(ovf));

  seq_mac #(.N(N), .R(1), .ACC_W(ACC_W)) u_r1 (
    .clk(clk), .rst(rst), .start(start_sw), .clr(clr), .A(A), .B(B),
    .busy(busy1), .done(done1), .P(P1), .ovf(ovf1));

  seq_mac #(.N(N), .R(3), .ACC_W(ACC_W)) u_r3 (
    .clk(clk), .rst(rst), .start(start_sw), .clr(clr), .A(A), .B(B),
    .busy(busy3), .done(done3), .P(P3), .ovf(ovf3));

  seq_mac #(.N(N), .R(8), .ACC_W(ACC_W)) u_r8 (
    .clk(clk), .rst(rst), .start(start_sw), .clr(clr), .A(A), .B(B),
    .busy(busy8), .done(done8), .P(P8), .ovf(ovf8));

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        c;
    logic        poke;   // pulse start again while RUN
    logic [19:0] p;
    logic        ov;
  } vec_t;

  typedef struct packed {
    logic [19:0] p;
    logic        ov;
  } exp_t;

  vec_t vecs[20];
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, expv);
    end
  endtask

  // One transaction on the R=2 instance; expected result queued at drive time.
  task automatic run_main(input vec_t v, input string name);
    exp_t e;
    int   lat;
    int   dones;
    int   busy_cyc;
    exp_q.push_back('{p: v.p, ov: v.ov});
    @(negedge clk);
    A = v.a; B = v.b; clr = v.c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = 8'($urandom); B = 8'($urandom); clr = 1'($urandom);
    busy_cyc = busy ? 1 : 0;
    lat   = 0;
    dones = 0;
    while (lat < 12 && dones == 0) begin
      start = (v.poke && lat == 1) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
      lat++;
      if (busy) busy_cyc++;
      if (done) dones++;
    end
    start = 1'b0;
    chk({name, " latency"}, 64'(lat), 64'd4);
    e = exp_q.pop_front();
    chk({name, " P"},   64'(P),   64'(e.p));
    chk({name, " ovf"}, 64'(ovf), 64'(e.ov));
    @(posedge clk); #1;
    busy_cyc += busy ? 1 : 0;
    chk({name, " done width"}, 64'(done), 64'd0);
    chk({name, " busy cycles"}, 64'(busy_cyc), 64'd5);
  endtask

  // One product on the R=1/3/8 instances in parallel.
  task automatic run_sweep(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] prod;
    int l1, l3, l8;
    prod = a * b;
    @(negedge clk);
    A = a; B = b; clr = 1'b1; start_sw = 1'b1;
    @(posedge clk); #1;
    start_sw = 1'b0; A = ~a; B = ~b; clr = 1'b0;
    l1 = -1; l3 = -1; l8 = -1;
    for (int t = 1; t <= 10; t++) begin
      @(posedge clk); #1;
      if (done1 && l1 < 0) l1 = t;
      if (done3 && l3 < 0) l3 = t;
      if (done8 && l8 < 0) l8 = t;
    end
    chk("r1 latency", 64'(l1), 64'd8);
    chk("r3 latency", 64'(l3), 64'd3);
    chk("r8 latency", 64'(l8), 64'd1);
    chk("r1 P", 64'(P1), 64'(prod));
    chk("r3 P", 64'(P3), 64'(prod));
    chk("r8 P", 64'(P8), 64'(prod));
  endtask

  initial begin
    int tot;
    int seen;
    logic [7:0] corner [7];
    vec_t v;

    // ---- vector table ----
    vecs[0] = '{a: 8'd13,  b: 8'd11,  c: 1'b1, poke: 1'b0, p: 20'd143,   ov: 1'b0};
    vecs[1] = '{a: 8'd255, b: 8'd255, c: 1'b0, poke: 1'b1, p: 20'd65168, ov: 1'b0};
    for (int j = 1; j <= 17; j++) begin
      tot = 65168 + j * 65025;
      vecs[1+j].a    = 8'd255;
      vecs[1+j].b    = 8'd255;
      vecs[1+j].c    = 1'b0;
      vecs[1+j].poke = 1'b0;
      vecs[1+j].p    = 20'(tot % (1 << 20));
      vecs[1+j].ov   = (tot >= (1 << 20));
    end
    vecs[19] = '{a: 8'd2, b: 8'd3, c: 1'b1, poke: 1'b0, p: 20'd6, ov: 1'b0};

    corner[0] = 8'd0;   corner[1] = 8'd1;   corner[2] = 8'd2;
    corner[3] = 8'd127; corner[4] = 8'd128; corner[5] = 8'd254;
    corner[6] = 8'd255;

    // ---- reset ----
    rst = 1'b1; start = 1'b0; start_sw = 1'b0; clr = 1'b0; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset P",    64'(P),    64'd0);
    chk("reset ovf",  64'(ovf),  64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset r8 P", 64'(P8),   64'd0);
    rst = 1'b0;

    // ---- table-driven accumulate sequence ----
    for (int i = 0; i < 20; i++) begin
      run_main(vecs[i], $sformatf("vec%0d", i));
    end

    // ---- reset on the second RUN cycle aborts the transaction ----
    @(negedge clk);
    A = 8'd100; B = 8'd100; clr = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort P",    64'(P),    64'd0);
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    chk("abort no done", 64'(seen), 64'd0);
    v = '{a: 8'd7, b: 8'd9, c: 1'b0, poke: 1'b0, p: 20'd63, ov: 1'b0};
    run_main(v, "post abort");

    // ---- R sweep: corner pairs plus random pairs ----
    foreach (corner[i]) begin
      foreach (corner[j]) begin
        run_sweep(corner[i], corner[j]);
      end
    end
    for (int i = 0; i < 200; i++) begin
      run_sweep(8'($urandom), 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
